// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: opcode constants, the NOP encoding and the fetch FSM state type.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    HOLD,
    DROP,
    HALT
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: instruction memory request/ack, branch redirect input and the valid/ready hand-off to decode.
interface instr_fetch_if #(
  parameter int XLEN = 32
);

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            id_valid;
  logic            id_ready;
  logic [31:0]     id_instr;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_pcplus4;
  logic            misalign;

  modport master (
    output imem_req, imem_addr, id_valid, id_instr, id_pc, id_pcplus4, misalign,
    input  imem_ack, imem_rdata, redirect, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_instr, id_pc, id_pcplus4, misalign,
    output imem_ack, imem_rdata, redirect, redirect_pc, id_ready
  );

endinterface

// File: rtl/pc_reg.sv
// Program counter register: async reset to RESET_PC, loads either pc+4 or the redirect target.
module pc_reg #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic            i_sel_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic [XLEN-1:0] o_pc
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_next;

  // Increment wraps naturally at 2^XLEN.
  assign w_pc_next = i_sel_redirect ? i_redirect_pc : r_pc + XLEN'(4);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (i_load) begin
      r_pc <= w_pc_next;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: one outstanding imem request, branch redirect with in-flight drop.
// Optional FETCH_MISALIGN_CHECK_EN halts fetch on a redirect to a non-word-aligned target.
module instr_fetch #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic           clk,
  input  logic           reset,
  instr_fetch_if.master  bus
);
  import riscv_pkg::*;

  fetch_state_t    r_state, w_state_nxt;
  logic            r_imem_req, w_imem_req_nxt;
  logic [XLEN-1:0] r_imem_addr, w_imem_addr_nxt;
  logic            r_id_valid, w_id_valid_nxt;
  logic [31:0]     r_id_instr, w_id_instr_nxt;
  logic [XLEN-1:0] r_id_pc, w_id_pc_nxt;
  logic            w_pc_load, w_pc_sel;
  logic [XLEN-1:0] w_pc, w_target;
  logic            w_bad_redirect;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic r_misalign;

  assign w_target       = bus.redirect_pc;
  assign w_bad_redirect = bus.redirect && (bus.redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_misalign <= 1'b0;
    end else if (r_state != HALT && w_bad_redirect) begin
      r_misalign <= 1'b1;
    end
  end

  assign bus.misalign = r_misalign;
`else
  // Low address bits of a target are forced to zero so fetch stays word-aligned.
  assign w_target       = bus.redirect_pc & {{(XLEN-2){1'b1}}, 2'b00};
  assign w_bad_redirect = 1'b0;
  assign bus.misalign   = 1'b0;
`endif

  pc_reg #(.XLEN(XLEN), .RESET_PC(RESET_PC)) u_pc_reg (
    .clk            (clk),
    .rst            (reset),
    .i_load         (w_pc_load),
    .i_sel_redirect (w_pc_sel),
    .i_redirect_pc  (w_target),
    .o_pc           (w_pc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_imem_req  <= 1'b0;
      r_imem_addr <= RESET_PC;
      r_id_valid  <= 1'b0;
      r_id_instr  <= NOP_INSTR;
      r_id_pc     <= RESET_PC;
    end else begin
      r_state     <= w_state_nxt;
      r_imem_req  <= w_imem_req_nxt;
      r_imem_addr <= w_imem_addr_nxt;
      r_id_valid  <= w_id_valid_nxt;
      r_id_instr  <= w_id_instr_nxt;
      r_id_pc     <= w_id_pc_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_imem_req_nxt  = r_imem_req;
    w_imem_addr_nxt = r_imem_addr;
    w_id_valid_nxt  = r_id_valid;
    w_id_instr_nxt  = r_id_instr;
    w_id_pc_nxt     = r_id_pc;
    w_pc_load       = 1'b0;
    w_pc_sel        = 1'b0;

    if (r_state != HALT && w_bad_redirect) begin
      w_state_nxt    = HALT;
      w_imem_req_nxt = 1'b0;
      w_id_valid_nxt = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt    = WAIT;
          w_imem_req_nxt = 1'b1;
          if (bus.redirect) begin
            w_pc_load       = 1'b1;
            w_pc_sel        = 1'b1;
            w_id_valid_nxt  = 1'b0;
            w_imem_addr_nxt = w_target;
          end else begin
            w_imem_addr_nxt = w_pc;
          end
        end
        WAIT: begin
          if (bus.redirect) begin
            w_pc_load      = 1'b1;
            w_pc_sel       = 1'b1;
            w_id_valid_nxt = 1'b0;
            if (bus.imem_ack) begin
              w_imem_req_nxt  = 1'b1;
              w_imem_addr_nxt = w_target;
            end else begin
              w_imem_req_nxt = 1'b0;
              w_state_nxt    = DROP;
            end
          end else if (bus.imem_ack) begin
            w_id_instr_nxt = bus.imem_rdata;
            w_id_pc_nxt    = w_pc;
            w_id_valid_nxt = 1'b1;
            w_pc_load      = 1'b1;
            w_imem_req_nxt = 1'b0;
            w_state_nxt    = HOLD;
          end
        end
        HOLD: begin
          if (bus.redirect) begin
            w_pc_load       = 1'b1;
            w_pc_sel        = 1'b1;
            w_id_valid_nxt  = 1'b0;
            w_imem_req_nxt  = 1'b1;
            w_imem_addr_nxt = w_target;
            w_state_nxt     = WAIT;
          end else if (bus.id_ready) begin
            w_id_valid_nxt  = 1'b0;
            w_imem_req_nxt  = 1'b1;
            w_imem_addr_nxt = w_pc;
            w_state_nxt     = WAIT;
          end
        end
        DROP: begin
          // A redirect coinciding with the dropped ack still retires the stale request.
          if (bus.redirect) begin
            w_pc_load = 1'b1;
            w_pc_sel  = 1'b1;
            if (bus.imem_ack) begin
              w_imem_req_nxt  = 1'b1;
              w_imem_addr_nxt = w_target;
              w_state_nxt     = WAIT;
            end
          end else if (bus.imem_ack) begin
            w_imem_req_nxt  = 1'b1;
            w_imem_addr_nxt = w_pc;
            w_state_nxt     = WAIT;
          end
        end
        default: begin
          w_imem_req_nxt = 1'b0;
          w_id_valid_nxt = 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req   = r_imem_req;
  assign bus.imem_addr  = r_imem_addr;
  assign bus.id_valid   = r_id_valid;
  assign bus.id_instr   = r_id_instr;
  assign bus.id_pc      = r_id_pc;
  assign bus.id_pcplus4 = r_id_pc + XLEN'(4);

endmodule
